// File: rtl/selftrigger_record_builder.sv
// Self-trigger record builder: ring-buffers the filtered stream and frames
// header / pre+post-trigger window / status trailer on a valid/ready stream.
module selftrigger_record_builder #(
   parameter int PRETRIG    = 64,
   parameter int RECORD_LEN = 256,
   parameter int BUF_AW     = 10
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic signed [15:0] x,
   input  logic signed [15:0] baseline,
   input  logic               trigger,
   input  logic [63:0]        timestamp,
   output logic [15:0]        dout,
   output logic               dout_valid,
   output logic               dout_last,
   input  logic               dout_ready,
   output logic               busy,
   output logic [15:0]        overrun_count
);

   localparam int DEPTH = 1 << BUF_AW;
   localparam int FW    = $clog2(PRETRIG + 1);
   localparam int SW    = $clog2(RECORD_LEN + 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_HEADER  = 2'd1;
   localparam logic [1:0] S_SAMPLES = 2'd2;
   localparam logic [1:0] S_TRAILER = 2'd3;

   logic [15:0]       mem [DEPTH];
   logic [15:0]       mem_q;
   logic [BUF_AW-1:0] wr_ptr;
   logic [BUF_AW-1:0] rd_ptr;
   logic [BUF_AW-1:0] unread;
   logic [FW-1:0]     fill;
   logic              trigger_d;
   logic              trig_edge;
   logic              accept;
   logic              ovf_hit;
   logic [1:0]        state;
   logic [2:0]        hcnt;
   logic [SW-1:0]     scnt;
   logic [7:0]        drop;
   logic              ovf;
   logic              enl;
   logic              t_sent;
   logic [63:0]       ts_q;
   logic [15:0]       bl_q;
   logic [15:0]       hword;

   logic              issue;
   logic              issue_raw;
   logic              issue_last;
   logic [15:0]       issue_d;

   logic              s1_v;
   logic              s1_raw;
   logic              s1_last;
   logic [15:0]       s1_d;
   logic [15:0]       s1_word;
   logic              sk_v;
   logic              sk_l;
   logic [15:0]       sk_d;
   logic              pop;
   logic [1:0]        occ;
   logic              can_issue;

   assign trig_edge = trigger & ~trigger_d;
   assign accept    = trig_edge & enable & (state == S_IDLE)
                    & (fill == FW'(PRETRIG));
   assign unread    = wr_ptr - rd_ptr;
   assign ovf_hit   = ((state == S_HEADER) || (state == S_SAMPLES))
                    && (unread == BUF_AW'(DEPTH - 2));
   assign pop       = dout_valid & dout_ready;
   assign busy      = (state != S_IDLE);
   assign s1_word   = s1_raw ? mem_q : s1_d;

   // Credit: at most two words may sit in output + skid once s1 lands.
   assign occ       = 2'(dout_valid) + 2'(sk_v) + 2'(s1_v);
   assign can_issue = (occ - 2'(pop)) < 2'd2;

   always_comb begin
      hword = bl_q;
      case (hcnt)
         3'd1:    hword = ts_q[63:48];
         3'd2:    hword = ts_q[47:32];
         3'd3:    hword = ts_q[31:16];
         3'd4:    hword = ts_q[15:0];
         default: hword = bl_q;
      endcase
   end

   always_comb begin
      issue      = 1'b0;
      issue_raw  = 1'b0;
      issue_last = 1'b0;
      issue_d    = '0;
      if (accept) begin
         issue   = 1'b1;
         issue_d = 16'hBEEF;
      end else if (state == S_HEADER && !ovf_hit && enable && can_issue) begin
         issue   = 1'b1;
         issue_d = hword;
      end else if (state == S_SAMPLES && !ovf_hit && enable && can_issue
                   && rd_ptr != wr_ptr) begin
         issue     = 1'b1;
         issue_raw = 1'b1;
      end else if (state == S_TRAILER && !t_sent && can_issue) begin
         issue      = 1'b1;
         issue_last = 1'b1;
         issue_d    = {drop, 5'b0, enl, ovf, 1'b0};
      end
   end

   always_ff @(posedge clk) begin
      if (enable) mem[wr_ptr] <= x;
      mem_q <= mem[rd_ptr];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fill          <= '0;
         trigger_d     <= 1'b1;
         state         <= S_IDLE;
         hcnt          <= '0;
         scnt          <= '0;
         drop          <= '0;
         ovf           <= 1'b0;
         enl           <= 1'b0;
         t_sent        <= 1'b0;
         ts_q          <= '0;
         bl_q          <= '0;
         overrun_count <= '0;
      end else begin
         trigger_d <= trigger;
         if (enable) wr_ptr <= wr_ptr + 1'b1;
         if (!enable) fill <= '0;
         else if (fill != FW'(PRETRIG)) fill <= fill + 1'b1;
         if (trig_edge && state != S_IDLE && drop != 8'hFF)
            drop <= drop + 1'b1;
         unique case (state)
            S_IDLE: begin
               if (accept) begin
                  ts_q   <= timestamp;
                  bl_q   <= baseline;
                  rd_ptr <= wr_ptr - BUF_AW'(PRETRIG);
                  scnt   <= SW'(RECORD_LEN);
                  drop   <= '0;
                  ovf    <= 1'b0;
                  enl    <= 1'b0;
                  t_sent <= 1'b0;
                  hcnt   <= 3'd1;
                  state  <= S_HEADER;
               end
            end
            S_HEADER, S_SAMPLES: begin
               if (ovf_hit) begin
                  ovf   <= 1'b1;
                  state <= S_TRAILER;
                  if (overrun_count != 16'hFFFF)
                     overrun_count <= overrun_count + 1'b1;
               end else if (!enable) begin
                  enl   <= 1'b1;
                  state <= S_TRAILER;
               end else if (issue && state == S_HEADER) begin
                  hcnt <= hcnt + 1'b1;
                  if (hcnt == 3'd5) state <= S_SAMPLES;
               end else if (issue) begin
                  rd_ptr <= rd_ptr + 1'b1;
                  scnt   <= scnt - 1'b1;
                  if (scnt == SW'(1)) state <= S_TRAILER;
               end
            end
            S_TRAILER: begin
               if (issue) t_sent <= 1'b1;
               if (pop && dout_last) state <= S_IDLE;
            end
         endcase
      end
   end

   // s1 always drains into the output register or the skid slot.
   always_ff @(posedge clk) begin
      if (reset) begin
         s1_v       <= 1'b0;
         s1_raw     <= 1'b0;
         s1_last    <= 1'b0;
         s1_d       <= '0;
         sk_v       <= 1'b0;
         sk_l       <= 1'b0;
         sk_d       <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         dout_last  <= 1'b0;
      end else begin
         s1_v    <= issue;
         s1_raw  <= issue_raw;
         s1_last <= issue_last;
         s1_d    <= issue_d;
         if (!dout_valid || pop) begin
            if (sk_v) begin
               dout       <= sk_d;
               dout_last  <= sk_l;
               dout_valid <= 1'b1;
               sk_v       <= s1_v;
               sk_d       <= s1_word;
               sk_l       <= s1_last;
            end else begin
               dout_valid <= s1_v;
               dout_last  <= s1_v & s1_last;
               if (s1_v) dout <= s1_word;
            end
         end else if (s1_v) begin
            sk_v <= 1'b1;
            sk_d <= s1_word;
            sk_l <= s1_last;
         end
      end
   end

endmodule

// File: tb/tb_selftrigger_record_builder.sv
// Directed bench for selftrigger_record_builder (PRETRIG=8, RECORD_LEN=16,
// BUF_AW=6); x and timestamp follow the cycle index.
module tb_selftrigger_record_builder;

   localparam int PRETRIG    = 8;
   localparam int RECORD_LEN = 16;
   localparam int BUF_AW     = 6;
   localparam int NWORDS     = RECORD_LEN + 7;

   logic               clk = 1'b1;
   logic               reset;
   logic               enable;
   logic signed [15:0] x;
   logic signed [15:0] baseline;
   logic               trigger;
   logic [63:0]        timestamp;
   logic [15:0]        dout;
   logic               dout_valid;
   logic               dout_last;
   logic               dout_ready;
   logic               busy;
   logic [15:0]        overrun_count;

   always #5 clk = ~clk;

   selftrigger_record_builder #(
      .PRETRIG(PRETRIG),
      .RECORD_LEN(RECORD_LEN),
      .BUF_AW(BUF_AW)
   ) dut (
      .clk(clk),
      .reset(reset),
      .enable(enable),
      .x(x),
      .baseline(baseline),
      .trigger(trigger),
      .timestamp(timestamp),
      .dout(dout),
      .dout_valid(dout_valid),
      .dout_last(dout_last),
      .dout_ready(dout_ready),
      .busy(busy),
      .overrun_count(overrun_count)
   );

   typedef struct {
      int          t;
      bit          rnd;
      int          edges;
      logic [15:0] trl;
   } vec_t;

   vec_t        vecs[4];
   int          checks = 0;
   int          failures = 0;
   int          cyc = 0;
   bit          rnd = 0;
   logic [16:0] got[$];
   logic [16:0] exp_q[$];
   int          first_v = -1;
   int          busy_seen = 0;
   int          valid_seen = 0;
   int          stab_err = 0;
   bit          hold_p = 0;
   logic [15:0] hold_d;
   logic        hold_l;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, expv);
      end
   endtask

   task automatic drive();
      x         = 16'(cyc);
      baseline  = 16'(cyc + 4096);
      timestamp = 64'(cyc);
      if (rnd) dout_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic step();
      @(negedge clk);
      if (hold_p && !(dout_valid && dout == hold_d && dout_last == hold_l))
         stab_err++;
      hold_p = dout_valid && !dout_ready;
      hold_d = dout;
      hold_l = dout_last;
      if (dout_valid && first_v < 0) first_v = cyc;
      if (dout_valid && dout_ready) got.push_back({dout_last, dout});
      busy_seen  += int'(busy);
      valid_seen += int'(dout_valid);
      @(posedge clk);
      #1;
      cyc++;
      drive();
   endtask

   function automatic bit rec_done();
      return got.size() > 0 && got[got.size() - 1][16];
   endfunction

   task automatic build(input int t, input logic [15:0] trl);
      logic [63:0] ts;
      ts = 64'(t);
      exp_q.delete();
      exp_q.push_back({1'b0, 16'hBEEF});
      exp_q.push_back({1'b0, ts[63:48]});
      exp_q.push_back({1'b0, ts[47:32]});
      exp_q.push_back({1'b0, ts[31:16]});
      exp_q.push_back({1'b0, ts[15:0]});
      exp_q.push_back({1'b0, 16'(t + 4096)});
      for (int i = 0; i < RECORD_LEN; i++)
         exp_q.push_back({1'b0, 16'(t - PRETRIG + i)});
      exp_q.push_back({1'b1, trl});
   endtask

   task automatic start(input int t);
      while (cyc < t) step();
      chk("start cycle", 64'(cyc), 64'(t));
      got.delete();
      first_v = -1;
      chk("idle before trigger", 64'(busy), 64'(0));
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      chk("busy at t0+1", 64'(busy), 64'(1));
   endtask

   task automatic wait_last(input string nm, input int t, input int edges);
      int k;
      k = 0;
      while (!rec_done() && k < 400) begin
         trigger = (edges > 0 && cyc == t + 10) ||
                   (edges > 1 && cyc == t + 12) ||
                   (edges > 2 && cyc == t + 14);
         step();
         k++;
      end
      trigger = 1'b0;
      chk({nm, " trailer seen"}, 64'(rec_done()), 64'(1));
      chk({nm, " busy after trailer"}, 64'(busy), 64'(0));
   endtask

   task automatic cmp_full(input string nm, input int t);
      int n;
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      chk({nm, " word count"}, 64'(got.size()), 64'(NWORDS));
      for (int i = 0; i < n; i++)
         chk($sformatf("%s w%0d", nm, i), 64'(got[i]), 64'(exp_q[i]));
      chk({nm, " header latency"}, 64'(first_v), 64'(t + 2));
   endtask

   task automatic cmp_prefix(input string nm, input logic [15:0] trl);
      int n;
      n = got.size();
      chk({nm, " short record"}, 64'(n > 0 && n < NWORDS), 64'(1));
      if (n > 0) begin
         chk({nm, " trailer"}, 64'(got[n - 1]), 64'({1'b1, trl}));
         for (int i = 0; i < n - 1; i++)
            chk($sformatf("%s w%0d", nm, i), 64'(got[i]), 64'(exp_q[i]));
      end
   endtask

   initial begin
      int t2;
      vecs[0] = '{100, 1'b0, 0, 16'h0000};
      vecs[1] = '{200, 1'b0, 3, 16'h0300};
      vecs[2] = '{300, 1'b1, 0, 16'h0000};
      vecs[3] = '{450, 1'b1, 2, 16'h0200};

      reset      = 1'b1;
      enable     = 1'b1;
      trigger    = 1'b0;
      dout_ready = 1'b1;
      drive();
      step();
      chk("reset dout_valid", 64'(dout_valid), 64'(0));
      chk("reset dout_last", 64'(dout_last), 64'(0));
      chk("reset dout", 64'(dout), 64'(0));
      chk("reset busy", 64'(busy), 64'(0));
      chk("reset overrun_count", 64'(overrun_count), 64'(0));
      step();
      reset = 1'b0;

      // Edge at cycle 5 arrives with only 3 samples buffered.
      busy_seen  = 0;
      valid_seen = 0;
      while (cyc < 5) step();
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      while (cyc < 20) step();
      chk("early trig busy", 64'(busy_seen), 64'(0));
      chk("early trig valid", 64'(valid_seen), 64'(0));

      trigger = 1'b1;
      reset   = 1'b1;
      step();
      step();
      reset      = 1'b0;
      busy_seen  = 0;
      valid_seen = 0;
      while (cyc < 40) step();
      trigger = 1'b0;
      while (cyc < 50) step();
      chk("held trig busy", 64'(busy_seen), 64'(0));
      chk("held trig valid", 64'(valid_seen), 64'(0));

      for (int v = 0; v < 4; v++) begin
         rnd = vecs[v].rnd;
         if (!rnd) dout_ready = 1'b1;
         start(vecs[v].t);
         wait_last($sformatf("vec%0d", v), vecs[v].t, vecs[v].edges);
         rnd        = 1'b0;
         dout_ready = 1'b1;
         build(vecs[v].t, vecs[v].trl);
         cmp_full($sformatf("vec%0d", v), vecs[v].t);
      end
      chk("hold stability", 64'(stab_err), 64'(0));

      // Back-to-back: edge on the first idle cycle after the trailer.
      start(600);
      wait_last("rt_a", 600, 0);
      build(600, 16'h0000);
      cmp_full("rt_a", 600);
      t2 = cyc;
      got.delete();
      first_v = -1;
      trigger = 1'b1;
      step();
      trigger = 1'b0;
      chk("rt_b busy", 64'(busy), 64'(1));
      wait_last("rt_b", t2, 0);
      build(t2, 16'h0000);
      cmp_full("rt_b", t2);

      start(700);
      for (int k = 0; k < 40 && got.size() < 3; k++) step();
      dout_ready = 1'b0;
      repeat (70) step();
      dout_ready = 1'b1;
      wait_last("ovr", 700, 0);
      build(700, 16'h0000);
      cmp_prefix("ovr", 16'h0002);
      chk("overrun_count", 64'(overrun_count), 64'(1));
      chk("hold stability ovr", 64'(stab_err), 64'(0));

      start(800);
      while (cyc < 810) step();
      enable = 1'b0;
      wait_last("enl", 800, 0);
      enable = 1'b1;
      build(800, 16'h0000);
      cmp_prefix("enl", 16'h0004);

      start(900);
      while (cyc < 910) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mid reset valid", 64'(dout_valid), 64'(0));
      chk("mid reset busy", 64'(busy), 64'(0));
      chk("mid reset ovr cnt", 64'(overrun_count), 64'(0));
      start(950);
      wait_last("post_rst", 950, 0);
      build(950, 16'h0000);
      cmp_full("post_rst", 950);
      chk("hold stability end", 64'(stab_err), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/selftrigger_record_builder.md
# selftrigger_record_builder

Downstream consumer of the self-trigger filter chain. It continuously buffers the filtered sample stream, and on each accepted trigger rising edge emits one framed record on a 16-bit valid/ready stream. A record is a header, a pre-/post-trigger sample window and a status trailer. The record stream feeds the channel's readout FIFO/serializer.

## Interface
Parameters:
- PRETRIG, 64: number of samples before the trigger sample included in the record.
- RECORD_LEN, 256: total samples per record, trigger sample included. Constraint: PRETRIG < RECORD_LEN < 2^BUF_AW − 8.
- BUF_AW, 10: ring buffer address width (depth 2^BUF_AW × 16 bit).

Ports:
- clk, in, 1: sample clock.
- reset, in, 1: synchronous, active-high.
- enable, in, 1: channel enable.
- x, in, 16 signed: filtered sample, one per clk.
- baseline, in, 16 signed: pedestal estimate, aligned with x.
- trigger, in, 1: trigger level, aligned with x.
- timestamp, in, 64: free-running timestamp, aligned with x.
- dout, out, 16: record word.
- dout_valid, out, 1: dout valid.
- dout_last, out, 1: high on the trailer word.
- dout_ready, in, 1: downstream accepts.
- busy, out, 1: high from trigger acceptance to trailer handshake.
- overrun_count, out, 16: saturating count of overrun-aborted records.

## Operation
- **Ring buffer:** written every cycle with enable=1: mem[wr_ptr] ← x, then wr_ptr+1 (mod 2^BUF_AW). No writes with enable=0.
- **fill counter:** counts writes, saturating at PRETRIG. It clears on reset, and on any cycle with enable=0.
- **Trigger edge:** trig_edge = trigger & ~trigger_d. trigger_d is reset to 1, so trigger held high out of reset does not fire.
- **Trigger acceptance** requires all of: trig_edge, enable=1, state IDLE, fill==PRETRIG.
- **On acceptance (cycle t0):**
  - Latch timestamp and baseline.
  - rd_ptr ← wr_ptr − PRETRIG (mod depth). The trigger sample is x at t0; the first record sample is x at t0−PRETRIG.
  - sample counter ← RECORD_LEN.
  - drop counter ← 0.
- **Triggers while busy:** a trig_edge outside IDLE increments an 8-bit drop counter (saturating 255). Edges in IDLE with fill<PRETRIG are ignored and not counted.
- **FSM states:**
  - IDLE → HEADER on acceptance.
  - HEADER emits 6 words in order: 0xBEEF, ts[63:48], ts[47:32], ts[31:16], ts[15:0], latched baseline. Then → SAMPLES.
  - SAMPLES emits RECORD_LEN words mem[rd_ptr++]. A sample is read only when rd_ptr ≠ wr_ptr; otherwise the output stalls (valid low) until written. Then → TRAILER.
  - TRAILER emits one word {drop[7:0], 5'b0, enable_lost, overrun, 1'b0} with dout_last=1. → IDLE on handshake.
- **Overrun:** the unread distance (wr_ptr − rd_ptr) reaches 2^BUF_AW − 2 while in HEADER or SAMPLES.
  - Jump to TRAILER, with overrun=1 and overrun_count+1 (saturating).
  - Remaining samples are not emitted.
  - This applies even while a word is held for backpressure. The held word completes its handshake first.
- **enable drops in HEADER/SAMPLES:** finish the word currently presented, then go to TRAILER with enable_lost=1.
- **Handshake:**
  - A word transfers on dout_valid & dout_ready.
  - While dout_valid=1 & dout_ready=0, dout/dout_valid/dout_last hold stable.
  - dout_valid never drops without a transfer, except under reset.
- **Reset:**
  - Returns to IDLE and clears wr_ptr, rd_ptr, fill, drop and overrun_count.
  - Outputs: dout=0, dout_valid=0, dout_last=0, busy=0, overrun_count=0.
  - A reset mid-record discards the record with no trailer.

## Timing
- Acceptance at t0: busy=1 at t0+1; header word 0 has dout_valid=1 at t0+2.
- Throughput is 1 word/clk with dout_ready held high. A full record is RECORD_LEN+7 words.
- Pre-trigger samples stream back-to-back after the header. Post-trigger samples are limited by arrival: sample k (k ≥ PRETRIG) is presented no earlier than 2 cycles after its write.
- Synchronous-read RAM with a 1-cycle read latency. A skid register holds one word so that backpressure never loses data.
- busy=0 the cycle after the trailer handshake. A new trigger edge is acceptable from that cycle on.

## Test plan
Parameters: PRETRIG=8, RECORD_LEN=16, BUF_AW=6. x is a ramp (x = cycle index from 0); timestamp is the same ramp.

1. **Single trigger.** Trigger rises at the sample with x=100, dout_ready=1.
   - Words: 0xBEEF, 0, 0, 0, 100, baseline, then samples 92..107, then trailer 0x0000 with last=1.
   - Header word 0 appears 2 cycles after the trigger.
2. **Early trigger / trigger held through reset.**
   - Trigger edge at x=5 (fill<8): no record, busy stays 0.
   - Trigger held high through reset release: no record until a fresh rising edge.
3. **Retrigger during record.** Three extra trigger edges during SAMPLES.
   - Record unchanged; trailer = 0x0300.
   - An edge one cycle after the trailer handshake starts a new record.
4. **Backpressure.** dout_ready toggled pseudo-randomly at 50%.
   - Record content is identical to scenario 1.
   - dout is stable while valid & !ready; no duplicates or drops.
5. **Overrun.** dout_ready=0 for 70 cycles after header word 2.
   - Trailer bit1=1 with last=1; fewer than 16 samples emitted.
   - overrun_count=1.
6. **Mid-record disruption.**
   - enable→0 during SAMPLES: trailer bit2=1.
   - reset during SAMPLES: dout_valid=0 the next cycle, then a new record works normally.
